mult_job_arbiter: RTL and testbench

- Sequences the shared 8-bit add-shift signed multiplier datapath: register A (accumulator), register X (sign bit), register B (multiplier), operand bus S.
- Two requesters share the datapath under round-robin arbitration.
- Per job: latches the winner's operands, drives load/add/subtract/shift controls for all 8 bit-steps, captures the 16-bit product {A,B}, pulses a per-requester done.
- Sits between requester logic and the datapath; it replaces switch/button-driven sequencing.

---
 rtl/mult_job_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mult_job_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_job_arbiter.sv
// mult_job_arbiter
// Round-robin job sequencer for a shared add-shift signed multiplier datapath
// (accumulator A, sign bit X, multiplier B, operand bus S). Two requesters
// compete for the datapath. For each granted job the block latches the
// winner's operands and steps the datapath through all WIDTH bit-steps. It
// then captures the 2*WIDTH-bit product {A,B} and pulses done to the
// requester that owned the job.
//
// Build option: define MULT_SKIP_ZERO_EN to fold the shift into the ADD
// cycle whenever the current multiplier bit is zero. Compute time then
// becomes WIDTH + popcount(multiplier) cycles instead of 2*WIDTH.

module mult_job_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [WIDTH-1:0]     mcand0,
  input  logic [WIDTH-1:0]     mplier0,
  input  logic [WIDTH-1:0]     mcand1,
  input  logic [WIDTH-1:0]     mplier1,
  output logic [1:0]           done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 owner,
  output logic [WIDTH-1:0]     dp_sw,
  output logic                 dp_clr_ld,
  output logic                 dp_addsub,
  output logic                 dp_sub_en,
  output logic                 dp_shift_en,
  input  logic                 dp_bout,
  input  logic [2*WIDTH-1:0]   dp_result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             last_served;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             any_req;
  logic             grant_id;
  logic             last_step;

  // Pick the winner: on contention take the requester not served last time.
  always_comb begin
    any_req = |req;
    if (req == 2'b11) begin
      grant_id = ~last_served;
    end else begin
      grant_id = req[1];
    end
  end

  assign last_step = (cnt == LAST_STEP);

  // Job sequencer: grant, load, WIDTH add/shift steps, then capture and notify.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      done        <= '0;
      result      <= '0;
      busy        <= 1'b0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt         <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= grant_id;
            mcand_q  <= grant_id ? mcand1 : mcand0;
            mplier_q <= grant_id ? mplier1 : mplier0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          state <= ADD;
        end
        ADD: begin
`ifdef MULT_SKIP_ZERO_EN
          // A zero multiplier bit needs no add, so its shift is issued here
          // and the separate SHIFT cycle is skipped.
          if (!dp_bout) begin
            if (last_step) begin
              done[owner] <= 1'b1;
              state       <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= SHIFT;
          end
`else
          state <= SHIFT;
`endif
        end
        SHIFT: begin
          if (last_step) begin
            done[owner] <= 1'b1;
            state       <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          result      <= dp_result;
          last_served <= owner;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state and step.
  always_comb begin
    dp_sw       = '0;
    dp_clr_ld   = 1'b0;
    dp_addsub   = 1'b0;
    dp_sub_en   = 1'b0;
    dp_shift_en = 1'b0;
    case (state)
      LOAD: begin
        dp_sw     = mplier_q;
        dp_clr_ld = 1'b1;
      end
      ADD: begin
        dp_sw     = mcand_q;
        dp_addsub = dp_bout;
        // The multiplier's sign bit carries negative weight.
        dp_sub_en = dp_bout && last_step;
`ifdef MULT_SKIP_ZERO_EN
        dp_shift_en = !dp_bout;
`endif
      end
      SHIFT: begin
        dp_shift_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mult_job_arbiter.sv
// Testbench for mult_job_arbiter. It includes a behavioural add-shift
// datapath, a transaction-level reference model with a scoreboard queue, and
// a separate monitor that checks the DUT against that model.

module tb_mult_job_arbiter;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic [1:0]     req;
  logic [W-1:0]   mcand0, mplier0, mcand1, mplier1;
  logic [1:0]     done;
  logic [2*W-1:0] result;
  logic           busy, owner;
  logic [W-1:0]   dp_sw;
  logic           dp_clr_ld, dp_addsub, dp_sub_en, dp_shift_en;
  logic           dp_bout;
  logic [2*W-1:0] dp_result;

  mult_job_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req),
    .mcand0(mcand0), .mplier0(mplier0), .mcand1(mcand1), .mplier1(mplier1),
    .done(done), .result(result), .busy(busy), .owner(owner),
    .dp_sw(dp_sw), .dp_clr_ld(dp_clr_ld), .dp_addsub(dp_addsub),
    .dp_sub_en(dp_sub_en), .dp_shift_en(dp_shift_en),
    .dp_bout(dp_bout), .dp_result(dp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared add-shift datapath ----------------
  logic [W-1:0] ra, rb;
  logic         rx;
  logic [W:0]   dp_sum;

  always_comb begin
    if (dp_sub_en) dp_sum = {ra[W-1], ra} - {dp_sw[W-1], dp_sw};
    else           dp_sum = {ra[W-1], ra} + {dp_sw[W-1], dp_sw};
  end

  always @(posedge clk) begin
    if (dp_clr_ld) begin
      ra <= '0; rx <= 1'b0; rb <= dp_sw;
    end else if (dp_addsub) begin
      rx <= dp_sum[W]; ra <= dp_sum[W-1:0];
    end else if (dp_shift_en) begin
      ra <= {rx, ra[W-1:1]}; rb <= {ra[0], rb[W-1:1]};
    end
  end

  assign dp_bout   = rb[0];
  assign dp_result = {ra, rb};

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    bit             id;
    logic [2*W-1:0] prod;
    int             dcyc;
    bit             sub;
  } exp_t;

  exp_t           q[$];
  int             cyc = 0;
  bit             have_reset = 0;
  int             free_at = 0;
  bit             last_srv = 1;
  logic [2*W-1:0] exp_result = '0;
  bit             exp_owner = 0;
  int             busy_lo = 0, busy_hi = -1;
  int             pend_cyc = -1;
  logic [2*W-1:0] pend_prod = '0;
  int             gnt_cnt[2] = '{0, 0};
  int             run_done[2] = '{0, 0};

  function automatic int job_len(input logic [W-1:0] mp);
`ifdef MULT_SKIP_ZERO_EN
    return W + $countones(mp);
`else
    return 2 * W;
`endif
  endfunction

  always @(posedge clk) begin : model
    int k;
    bit w;
    exp_t e;
    logic [W-1:0] mc, mp;
    k = cyc;
    if (reset) begin
      have_reset = 1;
      q.delete();
      free_at    = k + 1;
      last_srv   = 1;
      exp_result = '0;
      exp_owner  = 0;
      busy_lo    = 0;
      busy_hi    = -1;
      pend_cyc   = -1;
    end else if (have_reset) begin
      if (k == pend_cyc) exp_result = pend_prod;
      if (k >= free_at && req != 2'b00) begin
        w  = (req == 2'b11) ? !last_srv : req[1];
        mc = w ? mcand1 : mcand0;
        mp = w ? mplier1 : mplier0;
        e.id   = w;
        e.prod = 16'($signed(mc) * $signed(mp));
        e.dcyc = k + 2 + job_len(mp);
        e.sub  = mp[W-1];
        q.push_back(e);
        last_srv    = w;
        exp_owner   = w;
        busy_lo     = k + 1;
        busy_hi     = e.dcyc;
        free_at     = e.dcyc + 1;
        pend_cyc    = e.dcyc;
        pend_prod   = e.prod;
        run_done[w] = e.dcyc;
        gnt_cnt[w]  = gnt_cnt[w] + 1;
      end
    end
    cyc = k + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  int total = 0, bad = 0;
  int nshift = 0, nclr = 0, nsub = 0;
  int stim_to = 0, stim_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   eb;
    if (have_reset) begin
      chk("stim_wait", 32'(stim_to), 32'(stim_seen));
      stim_seen = stim_to;
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", 32'(busy), 32'(eb));
      chk("owner", 32'(owner), 32'(exp_owner));
      chk("result", 32'(result), 32'(exp_result));
      if (!eb) begin
        chk("idle_ctrl", 32'({dp_clr_ld, dp_addsub, dp_sub_en, dp_shift_en}), 32'(0));
        chk("idle_sw", 32'(dp_sw), 32'(0));
      end
      nshift += int'(dp_shift_en);
      nclr   += int'(dp_clr_ld);
      nsub   += int'(dp_sub_en);
      if (done != 2'b00) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'(0));
        end else begin
          e = q.pop_front();
          chk("done_id", 32'(done), e.id ? 32'd2 : 32'd1);
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          chk("shift_count", 32'(nshift), 32'(W));
          chk("clr_count", 32'(nclr), 32'(1));
          chk("sub_count", 32'(nsub), 32'(e.sub));
        end
        nshift = 0; nclr = 0; nsub = 0;
      end else if (q.size() > 0 && cyc > q[0].dcyc) begin
        chk("done_timeout", 32'(cyc), 32'(q[0].dcyc));
        void'(q.pop_front());
      end
      if (reset) begin
        nshift = 0; nclr = 0; nsub = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] mc, input logic [W-1:0] mp);
    if (id == 0) begin mcand0 = mc; mplier0 = mp; end
    else         begin mcand1 = mc; mplier1 = mp; end
  endtask

  task automatic wait_grant(input int id, input int g, output bit ok);
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      tick();
      ok = (gnt_cnt[id] != g);
    end
    if (!ok) stim_to++;
  endtask

  task automatic wait_cyc(input int t);
    for (int n = 0; n < 100 && cyc < t; n++) tick();
    if (cyc < t) stim_to++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; req = '0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic do_job(input int id, input logic [W-1:0] mc, input logic [W-1:0] mp);
    int g;
    bit ok;
    set_ops(id, mc, mp);
    g = gnt_cnt[id];
    req[id] = 1'b1;
    wait_grant(id, g, ok);
    if (ok) wait_cyc(run_done[id]);
    req[id] = 1'b0;
    repeat (2) tick();
  endtask

  initial begin : stim
    int  g, gc, rs[2], seen[2];
    bit  ok;
    reset = 1'b1; req = '0;
    mcand0 = '0; mplier0 = '0; mcand1 = '0; mplier1 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    do_job(0, 8'h07, 8'h03);
    do_job(1, 8'h05, 8'hFD);
    do_job(0, 8'h80, 8'h80);
    do_job(1, 8'h7F, 8'h81);

    // Both requesters held: alternating grants.
    do_reset(1);
    set_ops(0, 8'h02, 8'h02);
    set_ops(1, 8'h02, 8'h02);
    req = 2'b11;
    g = gnt_cnt[0] + gnt_cnt[1];
    for (int n = 0; n < 150 && (gnt_cnt[0] + gnt_cnt[1]) < g + 4; n++) tick();
    req = 2'b00;
    if ((gnt_cnt[0] + gnt_cnt[1]) < g + 4) stim_to++;
    repeat (25) tick();

    // Reset in the middle of a job.
    do_reset(1);
    set_ops(0, 8'h7F, 8'h7F);
    g = gnt_cnt[0];
    req[0] = 1'b1;
    wait_grant(0, g, ok);
    gc = cyc - 1;
    wait_cyc(gc + 8);
    do_reset(1);
    repeat (25) tick();

    // Requester drops req and changes operands after the grant.
    set_ops(0, 8'h03, 8'h04);
    g = gnt_cnt[0];
    req[0] = 1'b1;
    wait_grant(0, g, ok);
    gc = cyc - 1;
    wait_cyc(gc + 5);
    req[0] = 1'b0;
    mcand0 = 8'h00;
    wait_cyc(gc + 20);

    do_job(0, 8'h09, 8'h01);
    do_job(1, 8'hFF, 8'hFF);

    // Randomized traffic.
    rs[0] = 0; rs[1] = 0; seen[0] = 0; seen[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (rs[i] == 1 && gnt_cnt[i] != seen[i]) rs[i] = 2;
        if (rs[i] == 2 && cyc > run_done[i]) rs[i] = 0;
        case (rs[i])
          0: begin
            set_ops(i, W'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0) begin
              req[i]  = 1'b1;
              rs[i]   = 1;
              seen[i] = gnt_cnt[i];
            end else begin
              req[i] = 1'b0;
            end
          end
          1: req[i] = 1'b1;
          default: begin
            req[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) set_ops(i, W'($urandom), W'($urandom));
          end
        endcase
      end
      tick();
    end
    req = 2'b00;
    repeat (45) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
